// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the memory-port arbiter: FSM encoding, owner
// constants and default bus widths.
package cpu_mem_pkg;

    localparam int unsigned AW_DEF = 16;
    localparam int unsigned DW_DEF = 8;
    localparam int unsigned WW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// whichever port was not granted last.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_grant,
    output logic gnt_valid_c,
    output logic gnt_owner_c
);

    always_comb begin
        gnt_valid_c = cpu_req | dbg_req;
        gnt_owner_c = OWN_CPU;
        if (cpu_req && dbg_req) begin
            gnt_owner_c = ~last_grant;
        end else if (dbg_req) begin
            gnt_owner_c = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the CPU and the debug/loader port.
// Each granted access runs wait_cfg+1 strobe cycles then a one-cycle ack.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF,
    parameter int unsigned WW = WW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [WW-1:0] wait_cfg,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_read,
    output logic          mem_write,
    output logic          busy,
    output logic          owner
);

    state_e        state, state_nxt;
    logic [WW-1:0] cnt, cnt_nxt;
    logic          we_q, we_nxt;
    logic          last_grant, last_nxt;
    logic          owner_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] wdata_nxt;
    logic          read_nxt, write_nxt;
    logic          cpu_ack_nxt, dbg_ack_nxt;
    logic [DW-1:0] cpu_rdata_nxt, dbg_rdata_nxt;
    logic          busy_nxt;
    logic          gnt_valid_c, gnt_owner_c;

    rr_arb2 u_arb (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .last_grant  (last_grant),
        .gnt_valid_c (gnt_valid_c),
        .gnt_owner_c (gnt_owner_c)
    );

    // Next-state and next-output logic; strobes/acks are rebuilt every cycle.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        we_nxt        = we_q;
        last_nxt      = last_grant;
        owner_nxt     = owner;
        addr_nxt      = mem_addr;
        wdata_nxt     = mem_wdata;
        read_nxt      = 1'b0;
        write_nxt     = 1'b0;
        cpu_ack_nxt   = 1'b0;
        dbg_ack_nxt   = 1'b0;
        cpu_rdata_nxt = cpu_rdata;
        dbg_rdata_nxt = dbg_rdata;

        case (state)
            IDLE: begin
                if (gnt_valid_c) begin
                    owner_nxt = gnt_owner_c;
                    last_nxt  = gnt_owner_c;
                    we_nxt    = (gnt_owner_c == OWN_DBG) ? dbg_we    : cpu_we;
                    addr_nxt  = (gnt_owner_c == OWN_DBG) ? dbg_addr  : cpu_addr;
                    wdata_nxt = (gnt_owner_c == OWN_DBG) ? dbg_wdata : cpu_wdata;
                    cnt_nxt   = wait_cfg;
                    read_nxt  = ~we_nxt;
                    write_nxt = we_nxt;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    // Last strobe cycle: mem_rdata is valid now.
                    if (!we_q) begin
                        if (owner == OWN_DBG) begin
                            dbg_rdata_nxt = mem_rdata;
                        end else begin
                            cpu_rdata_nxt = mem_rdata;
                        end
                    end
                    cpu_ack_nxt = (owner == OWN_CPU);
                    dbg_ack_nxt = (owner == OWN_DBG);
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt   = cnt - WW'(1);
                    read_nxt  = ~we_q;
                    write_nxt = we_q;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            last_grant <= OWN_DBG;
            owner      <= OWN_CPU;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            we_q       <= we_nxt;
            last_grant <= last_nxt;
            owner      <= owner_nxt;
            mem_addr   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            mem_read   <= read_nxt;
            mem_write  <= write_nxt;
            cpu_ack    <= cpu_ack_nxt;
            dbg_ack    <= dbg_ack_nxt;
            cpu_rdata  <= cpu_rdata_nxt;
            dbg_rdata  <= dbg_rdata_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses,
// a negedge monitor checks arbitration, strobe timing, acks and read data.
module tb_mem_port_arbiter;
    import cpu_mem_pkg::*;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned WW = 4;

    logic          clk;
    logic          rst;
    logic [WW-1:0] wait_cfg;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
    logic          cpu_ack, dbg_ack, mem_read, mem_write, busy, owner;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } txn_t;

    txn_t        q_cpu[$];
    txn_t        q_dbg[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    bit          mon_en = 0;
    bit          rand_on = 0;
    logic [7:0]  dev_mem [0:65535];
    logic [7:0]  ref_mem [logic [15:0]];

    mem_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .wait_cfg  (wait_cfg),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .dbg_ack   (dbg_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory device: power-up pattern, one preset word, writes on strobe.
    initial begin
        for (int i = 0; i < 65536; i++) dev_mem[i] = init_val(16'(i));
        dev_mem[16'h0012] = 8'hA5;
    end
    always @(posedge clk) if (mem_write) dev_mem[mem_addr] <= mem_wdata;
    always @(negedge clk) mem_rdata <= mem_read ? dev_mem[mem_addr] : 8'($urandom);

    function automatic logic [63:0] all_outs();
        return 64'({cpu_rdata, dbg_rdata, cpu_ack, dbg_ack, mem_addr, mem_wdata,
                    mem_read, mem_write, busy, owner});
    endfunction

    // Issue one access from port p and wait for its ack.
    task automatic txn(input bit p, input bit we, input logic [15:0] a, input logic [7:0] d,
                       input bit keep, input bit drop_early);
        txn_t e;
        bit   got;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        if (we) begin
            ref_mem[a] = d;
            e.rdata    = 8'h00;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        end
        if (p) q_dbg.push_back(e); else q_cpu.push_back(e);
        if (p) begin
            dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        if (drop_early) begin
            @(posedge clk); #1;
            if (p) begin dbg_req = 1'b0; dbg_addr = 16'($urandom); end
            else   begin cpu_req = 1'b0; cpu_addr = 16'($urandom); end
        end
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = p ? dbg_ack : cpu_ack;
        end
        chk(p ? "dbg_ack_arrived" : "cpu_ack_arrived", 64'(got), 64'(1));
        @(posedge clk); #1;
        if (!keep) begin
            if (p) begin dbg_req = 1'b0; dbg_wdata = 8'($urandom); end
            else   begin cpu_req = 1'b0; cpu_wdata = 8'($urandom); end
        end
    endtask

    // Monitor: grants, strobe shape, ack timing and read-data scoreboard.
    initial begin : monitor
        bit          prev_strobe, prev_creq, prev_dreq, tb_last, cur_own, cur_we, exp_own, strobe, ap;
        logic [3:0]  prev_w, cur_w;
        logic [15:0] cur_addr;
        logic [7:0]  cur_wdata;
        logic [7:0]  rd_exp [2];
        int unsigned start_cyc, slen;
        txn_t        e;
        int          qs;
        prev_strobe = 0; prev_creq = 0; prev_dreq = 0; tb_last = OWN_DBG;
        cur_own = 0; cur_we = 0; prev_w = 0; cur_w = 0; cur_addr = 0; cur_wdata = 0;
        rd_exp[0] = 0; rd_exp[1] = 0; start_cyc = 0; slen = 0;
        forever begin
            @(negedge clk);
            strobe = mem_read | mem_write;
            if (!mon_en) begin
                strobe = 0; tb_last = OWN_DBG; rd_exp[0] = 0; rd_exp[1] = 0; slen = 0;
            end else begin
                if (strobe) chk("strobe_exclusive", 64'(mem_read & mem_write), 64'(0));
                if (cpu_ack || dbg_ack) chk("ack_exclusive", 64'(cpu_ack & dbg_ack), 64'(0));
                if (strobe && !prev_strobe) begin
                    chk("grant_had_request", 64'(prev_creq | prev_dreq), 64'(1));
                    exp_own = (prev_creq && prev_dreq) ? !tb_last : !prev_creq;
                    chk("arb_owner", 64'(owner), 64'(exp_own));
                    tb_last = exp_own; cur_own = exp_own; cur_w = prev_w;
                    start_cyc = cyc; slen = 0;
                    qs = exp_own ? q_dbg.size() : q_cpu.size();
                    chk("txn_pending", 64'(qs != 0), 64'(1));
                    if (qs != 0) begin
                        e = exp_own ? q_dbg[0] : q_cpu[0];
                        cur_addr = e.addr; cur_we = e.we; cur_wdata = e.wdata;
                        chk("mem_addr", 64'(mem_addr), 64'(e.addr));
                        chk("mem_write_dir", 64'(mem_write), 64'(e.we));
                        chk("mem_read_dir", 64'(mem_read), 64'(!e.we));
                        if (e.we) chk("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
                    end
                end else if (strobe) begin
                    chk("addr_stable", 64'(mem_addr), 64'(cur_addr));
                    chk("dir_stable", 64'(mem_write), 64'(cur_we));
                    if (cur_we) chk("wdata_stable", 64'(mem_wdata), 64'(cur_wdata));
                end
                if (strobe) slen++;
                if (!strobe && prev_strobe) chk("strobe_len", 64'(slen), 64'(cur_w) + 64'(1));
                if (cpu_ack || dbg_ack) begin
                    ap = dbg_ack;
                    chk("ack_owner", 64'(ap), 64'(cur_own));
                    chk("ack_latency", 64'(cyc - start_cyc), 64'(cur_w) + 64'(1));
                    chk("busy_in_done", 64'(busy), 64'(1));
                    qs = ap ? q_dbg.size() : q_cpu.size();
                    if (qs != 0) begin
                        e = ap ? q_dbg.pop_front() : q_cpu.pop_front();
                        if (!e.we) rd_exp[ap] = e.rdata;
                    end
                    chk("cpu_rdata", 64'(cpu_rdata), 64'(rd_exp[0]));
                    chk("dbg_rdata", 64'(dbg_rdata), 64'(rd_exp[1]));
                end
            end
            prev_strobe = strobe;
            prev_creq   = cpu_req;
            prev_dreq   = dbg_req;
            prev_w      = wait_cfg;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit seen;
        rst = 1'b0; wait_cfg = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outputs", all_outs(), 64'(0));

        // Asynchronous reset in the middle of a W=3 read.
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        wait_cfg = 4'd3; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = mem_read;
        end
        chk("pre_reset_strobe_seen", 64'(seen), 64'(1));
        #2 rst = 1'b0;
        #1 chk("async_reset_strobes", 64'({mem_read, mem_write}), 64'(0));
        chk("async_reset_outputs", all_outs(), 64'(0));
        cpu_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) begin rst = 1'b1; mon_en = 1; end
        @(posedge clk); #1;

        // First tie after reset goes to the CPU; CPU read W=0 of a preset word.
        wait_cfg = 4'd0;
        ref_mem[16'h0012] = 8'hA5;
        fork
            txn(1'b0, 1'b0, 16'h0012, 8'h00, 1'b0, 1'b0);
            txn(1'b1, 1'b1, 16'h8001, 8'h77, 1'b0, 1'b0);
        join
        chk("cpu_read_a5", 64'(cpu_rdata), 64'(8'hA5));

        // Debug write, W=2; CPU side untouched.
        wait_cfg = 4'd2;
        txn(1'b1, 1'b1, 16'h8000, 8'h3C, 1'b0, 1'b0);
        chk("cpu_rdata_untouched", 64'(cpu_rdata), 64'(8'hA5));

        // Both ports held continuously, W=1: alternation.
        wait_cfg = 4'd1;
        fork
            for (int i = 0; i < 4; i++)
                txn(1'b0, 1'($urandom_range(0, 1)), {8'h00, 8'($urandom_range(0, 15))},
                    8'($urandom), i < 3, 1'b0);
            for (int i = 0; i < 4; i++)
                txn(1'b1, 1'($urandom_range(0, 1)), {8'h80, 8'($urandom_range(0, 15))},
                    8'($urandom), i < 3, 1'b0);
        join

        // wait_cfg 1 -> 7 mid-access: 2 strobes now, 8 on the next access.
        wait_cfg = 4'd1;
        fork
            begin
                txn(1'b0, 1'b0, 16'h0007, 8'h00, 1'b1, 1'b0);
                txn(1'b0, 1'b1, 16'h0008, 8'h9E, 1'b0, 1'b0);
            end
            begin
                seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = mem_read | mem_write;
                end
                @(posedge clk); #1 wait_cfg = 4'd7;
            end
        join

        // CPU drops its request in the first ACCESS cycle, W=4.
        wait_cfg = 4'd4;
        txn(1'b0, 1'b0, 16'h0003, 8'h00, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("idle_after_drop", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // Maximum wait states with write then readback.
        wait_cfg = 4'd15;
        txn(1'b0, 1'b1, 16'h0005, 8'hC3, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 16'h0005, 8'h00, 1'b0, 1'b0);
        chk("w15_readback", 64'(cpu_rdata), 64'(8'hC3));

        // Randomized traffic from both ports with changing wait_cfg.
        rand_on = 1;
        fork
            while (rand_on) begin
                @(posedge clk); #1;
                if ($urandom_range(0, 3) == 0) wait_cfg = 4'($urandom_range(0, 15));
            end
            begin
                fork
                    for (int i = 0; i < 25; i++) begin
                        bit k;
                        k = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
                        txn(1'b0, 1'($urandom_range(0, 1)), {8'h00, 8'($urandom_range(0, 15))},
                            8'($urandom), k, 1'b0);
                        if (!k) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    end
                    for (int i = 0; i < 25; i++) begin
                        bit k;
                        k = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
                        txn(1'b1, 1'($urandom_range(0, 1)), {8'h80, 8'($urandom_range(0, 15))},
                            8'($urandom), k, 1'b0);
                        if (!k) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    end
                join
                rand_on = 0;
            end
        join

        repeat (5) @(negedge clk);
        chk("cpu_queue_drained", 64'(q_cpu.size()), 64'(0));
        chk("dbg_queue_drained", 64'(q_dbg.size()), 64'(0));
        chk("final_idle", 64'(busy), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single external memory port (16-bit address, 8-bit data, separate read/write strobes) between two requesters: the CPU datapath/controller and a debug/program-loader port.
Each access is sequenced through a small FSM with a programmable number of wait states, followed by a one-cycle acknowledge to the owning requester.
Arbitration is two-way round-robin.
The block sits between the CPU's memaddr/data_in/data_out/read/write signals and the memory model or on-board RAM.

Parameters:
AW, 16, address width
DW, 8, data width
WW, 4, width of the wait-state configuration and counter

Ports:
clk  input  1  system clock (rising edge)
rst  input  1  asynchronous, active-low reset
wait_cfg  input  WW  wait states per access; sampled only when an access is granted
cpu_req  input  1  CPU access request (level)
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  AW  CPU address
cpu_wdata  input  DW  CPU write data
cpu_rdata  output  DW  read data returned to CPU
cpu_ack  output  1  one-cycle completion pulse to CPU
dbg_req  input  1  debug/loader request (level)
dbg_we  input  1  1 = write, 0 = read
dbg_addr  input  AW  debug address
dbg_wdata  input  DW  debug write data
dbg_rdata  output  DW  read data returned to debug port
dbg_ack  output  1  one-cycle completion pulse to debug port
mem_addr  output  AW  registered memory address
mem_wdata  output  DW  registered memory write data
mem_rdata  input  DW  memory read data, valid during the last ACCESS cycle
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
busy  output  1  high whenever state != IDLE
owner  output  1  current or last owner: 0 = CPU, 1 = debug

Behaviour:
- Reset (rst low, asynchronous): state = IDLE. All outputs go to 0 immediately, including mem_read, mem_write, both acks, both rdata, mem_addr and mem_wdata. last_grant = debug, so the CPU wins the first tie. Wait counter = 0.
- FSM states are IDLE, ACCESS and DONE.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - On grant: register owner, we, addr and wdata from the granted port; load cnt = wait_cfg; update last_grant; go to ACCESS.
- ACCESS:
  - mem_read = !we and mem_write = we, both asserted for every ACCESS cycle. mem_addr and mem_wdata stay stable for the whole access.
  - If cnt == 0: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged), then go to DONE.
  - Otherwise decrement cnt.
- DONE:
  - Strobes are low.
  - Pulse the owner's ack high for exactly one cycle.
  - All requests are ignored.
  - Go to IDLE.
- Timing, with W = wait_cfg and the request sampled in IDLE cycle t:
  - Strobes are high in cycles t+1 .. t+W+1 (W+1 cycles).
  - Ack is high in cycle t+W+2.
  - Back-to-back accesses from one requester complete every W+3 cycles.
- Handshake rules:
  - A requester holds req and its address/data until its ack.
  - A requester must drop req at the clock edge that ends its ack cycle. If req is still high in the following IDLE cycle, that starts a new access.
  - Changes to the granted port's inputs during ACCESS have no effect, because all access fields are registered.
- Request dropped mid-access: no abort. The access completes and the ack still pulses.
- rdata registers hold their value until the next read by the same owner.
- wait_cfg changes mid-access do not affect the current access.
- W = 0 gives the minimum access: one strobe cycle, with ack 2 cycles after grant.
- W = max (15) gives 16 strobe cycles. The counter never wraps.
- mem_read and mem_write are never high together. Both acks are never high together.
- The non-owner's ack and rdata are unaffected by the other port's traffic.

Decomposition:
- Shared package cpu_mem_pkg:
  - FSM state encoding: IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2.
  - Owner constants: OWN_CPU = 1'b0, OWN_DBG = 1'b1.
  - Default AW/DW/WW widths.
- One sub-module: rr_arb2, the combinational two-way round-robin grant from (cpu_req, dbg_req, last_grant).
- The FSM, counter and registered memory outputs stay in mem_port_arbiter.

Test Plan:
- Reset while in ACCESS, W = 3 -> mem_read/mem_write drop immediately. After release, the first tie (both req high) grants the CPU: owner = 0.
- CPU read, addr 16'h0012, W = 0, mem_rdata = 8'hA5 -> mem_read high 1 cycle with mem_addr = 0012. cpu_ack 2 cycles after the request is sampled. cpu_rdata = 8'hA5.
- Debug write, addr 16'h8000, data 8'h3C, W = 2 -> mem_write high 3 cycles with mem_wdata = 3C. dbg_ack at cycle +4. cpu_ack stays 0 and cpu_rdata is unchanged.
- Both requests held continuously, W = 1 -> grants alternate CPU, DBG, CPU, DBG. Accesses complete every 4 cycles. Acks never overlap.
- Change wait_cfg from 1 to 7 during an access -> the current access keeps 2 strobe cycles; the next access gets 8.
- CPU drops req in the first ACCESS cycle, W = 4 -> the access still runs 5 strobe cycles and cpu_ack pulses. The FSM returns to IDLE and no further access starts.
